// File: rtl/proc_pkg.sv
// Shared processor definitions: loader FSM states and instruction-word constants
// used by the program store and the decode stage.
package proc_pkg;

    // Program store operating modes.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Instruction width shared with decode.
    localparam int INST_W = 16;

    // Encoding of the no-operation instruction.
    localparam logic [INST_W-1:0] NOP_DEFAULT = '0;

endpackage

// File: rtl/program_ram_array.sv
// Single-port synchronous RAM holding the program image.
// One access per cycle: a write when we=1, otherwise a registered read.
module program_ram_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write or registered read of the addressed word.
    // NOTE: the array and read register have no reset so the tool can map them
    // onto a block RAM; the loader clears the contents explicitly after reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/program_ram_loader.sv
// Writable instruction store: clears itself to NOP after reset, serves
// one-cycle-latency fetches, and accepts sequential program downloads over a
// valid/ready port. Fetch and load are mutually exclusive by state, so the
// single RAM port is never contended.
module program_ram_loader
    import proc_pkg::*;
#(
    parameter int                 DATA_W   = INST_W,
    parameter int                 ADDR_W   = 4,
    parameter int                 DEPTH    = 16,
    parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_inst,
    output logic              fetch_err,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;       // clear pointer in CLEAR, write pointer in LOAD
    logic [DATA_W-1:0] inst_hold_q;        // last presented instruction

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic fetch_fire;
    logic fetch_oor;
    logic load_fire;
    logic load_end;

    assign fetch_fire = fetch_req & fetch_ready;
    assign fetch_oor  = ({1'b0, fetch_addr} >= DEPTH_EXT);
    assign load_fire  = load_valid & load_ready;
    // A download ends on an accepted word flagged last, or on the top word.
    assign load_end   = load_fire & (load_last | (ptr_q == LAST_ADDR));

    program_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Next-state, pointer, handshake and RAM-port steering.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        fetch_ready = 1'b0;
        load_ready  = 1'b0;
        busy        = 1'b1;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = ptr_q;
        ram_wdata   = NOP_WORD;

        case (state_q)
            ST_CLEAR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end

            ST_RUN: begin
                busy        = 1'b0;
                fetch_ready = 1'b1;
                // Out-of-range fetches never touch the array.
                ram_en      = fetch_req & ~fetch_oor;
                ram_addr    = fetch_addr;
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end
            end

            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_wdata = load_data;
                    ptr_d     = ptr_q + ADDR_W'(1);
                end
                if (load_end) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end
            end

            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // State and pointer registers; reset restarts the clear sweep from 0.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Fetch response flags: one-cycle pulses following an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            fetch_valid <= fetch_fire;
            fetch_err   <= fetch_fire & fetch_oor;
        end
    end

    // Holds the presented instruction so fetch_inst is stable between fetches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_hold_q <= '0;
        end else begin
            inst_hold_q <= fetch_inst;
        end
    end

    // Presented instruction: fresh RAM data, NOP for out-of-range, else held.
    always_comb begin
        fetch_inst = inst_hold_q;
        if (fetch_valid) begin
            fetch_inst = fetch_err ? NOP_WORD : ram_rdata;
        end
    end

    // Download completion pulse and word count, captured on the final word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_done  <= 1'b0;
            load_count <= '0;
        end else begin
            load_done <= load_end;
            if (load_end) begin
                load_count <= {1'b0, ptr_q} + (ADDR_W + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_program_ram_loader.sv
// Self-checking bench for program_ram_loader: directed scenarios plus
// randomized downloads and fetches compared against an array model.
module tb_program_ram_loader;

    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 4;
    localparam int          DEPTH  = 16;
    localparam int          D12    = 12;
    localparam logic [15:0] NOP12  = 16'hF00F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default-parameter instance.
    logic              fetch_req, fetch_ready, fetch_valid, fetch_err;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_inst;
    logic              load_start, load_valid, load_last, load_ready, load_done, busy;
    logic [DATA_W-1:0] load_data;
    logic [ADDR_W:0]   load_count;

    // DEPTH=12 instance with a non-zero NOP word.
    logic              b_fetch_req, b_fetch_ready, b_fetch_valid, b_fetch_err;
    logic [ADDR_W-1:0] b_fetch_addr;
    logic [DATA_W-1:0] b_fetch_inst;
    logic              b_load_start, b_load_valid, b_load_last, b_load_ready, b_load_done, b_busy;
    logic [DATA_W-1:0] b_load_data;
    logic [ADDR_W:0]   b_load_count;

    program_ram_loader dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_err(fetch_err),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .load_count(load_count), .busy(busy)
    );

    program_ram_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(D12), .NOP_WORD(NOP12)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr), .fetch_ready(b_fetch_ready),
        .fetch_valid(b_fetch_valid), .fetch_inst(b_fetch_inst), .fetch_err(b_fetch_err),
        .load_start(b_load_start), .load_valid(b_load_valid), .load_data(b_load_data),
        .load_last(b_load_last), .load_ready(b_load_ready), .load_done(b_load_done),
        .load_count(b_load_count), .busy(b_busy)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_mem [DEPTH];   // expected program image
    logic [15:0] ld [DEPTH];          // words of the next download
    logic [15:0] exp_hold;            // expected held fetch_inst

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fetch_valid"}, fetch_valid, 0);
        check({tag, "_fetch_inst"},  fetch_inst,  0);
        check({tag, "_fetch_err"},   fetch_err,   0);
        check({tag, "_load_done"},   load_done,   0);
        check({tag, "_load_count"},  load_count,  0);
        check({tag, "_fetch_ready"}, fetch_ready, 0);
        check({tag, "_load_ready"},  load_ready,  0);
        check({tag, "_busy"},        busy,        1);
    endtask

    // Runs from reset release until both instances leave CLEAR; checks lengths.
    task automatic measure_clear(input string tag);
        int n16 = -1;
        int n12 = -1;
        bit leak = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (!busy && n16 < 0)   n16 = cyc;
            if (!b_busy && n12 < 0) n12 = cyc;
            if (n16 >= 0 && n12 >= 0) break;
            if (busy && (fetch_ready || fetch_valid || load_ready)) leak = 1'b1;
            step();
        end
        check({tag, "_clear_cycles16"}, n16, DEPTH);
        check({tag, "_clear_cycles12"}, n12, D12);
        check({tag, "_no_activity_in_clear"}, leak, 0);
    endtask

    // Back-to-back fetches of the given addresses, then one idle cycle.
    task automatic fetch_list(input string tag, input int addrs[$]);
        foreach (addrs[i]) begin
            fetch_req  = 1'b1;
            fetch_addr = addrs[i][ADDR_W-1:0];
            step();
            check({tag, "_valid"}, fetch_valid, 1);
            check({tag, "_inst"},  fetch_inst,  model_mem[addrs[i]]);
            exp_hold = model_mem[addrs[i]];
        end
        fetch_req = 1'b0;
        step();
        check({tag, "_idle_valid"}, fetch_valid, 0);
        check({tag, "_idle_hold"},  fetch_inst,  exp_hold);
    endtask

    task automatic start_load(input string tag);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check({tag, "_start_busy"},        busy,        1);
        check({tag, "_start_load_ready"},  load_ready,  1);
        check({tag, "_start_fetch_ready"}, fetch_ready, 0);
    endtask

    // Sends ld[0..n-1] with random idle gaps and random noise on the ignored
    // inputs; expects completion after the n-th word. Assumes LOAD state.
    task automatic load_words(input string tag, input int n, input bit use_last);
        int  dones = 0;
        int  i     = 0;
        bit  fetch_leak = 1'b0;
        for (int guard = 0; guard < 200 && i < n; guard++) begin
            load_start = 1'($urandom_range(0, 1));
            fetch_req  = 1'($urandom_range(0, 1));
            fetch_addr = ADDR_W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                load_last  = 1'($urandom_range(0, 1));
                load_data  = 16'($urandom);
            end else begin
                load_valid = 1'b1;
                load_data  = ld[i];
                load_last  = use_last && (i == n - 1);
                i++;
            end
            step();
            if (load_done) dones++;
            if (fetch_valid) fetch_leak = 1'b1;
        end
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        fetch_req  = 1'b0;
        check({tag, "_done_pulses"}, dones, 1);
        check({tag, "_done_now"},    load_done, 1);
        check({tag, "_count"},       load_count, n);
        check({tag, "_back_to_run"}, busy, 0);
        check({tag, "_no_fetch"},    fetch_leak, 0);
        for (int k = 0; k < n; k++) model_mem[k] = ld[k];
        step();
        check({tag, "_done_cleared"}, load_done, 0);
        check({tag, "_count_stable"}, load_count, n);
    endtask

    initial begin
        rst_n        = 1'b0;
        fetch_req    = 1'b1;
        fetch_addr   = 4'd3;
        load_start   = 1'b0;
        load_valid   = 1'b0;
        load_last    = 1'b0;
        load_data    = '0;
        b_fetch_req  = 1'b0;
        b_fetch_addr = '0;
        b_load_start = 1'b0;
        b_load_valid = 1'b0;
        b_load_last  = 1'b0;
        b_load_data  = '0;
        exp_hold     = '0;
        for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;

        // Reset values, then clear length with a fetch held pending.
        repeat (3) step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        measure_clear("boot");
        check("boot_fetch_ready", fetch_ready, 1);
        check("boot_no_valid_yet", fetch_valid, 0);
        step();
        check("boot_first_valid", fetch_valid, 1);
        check("boot_first_inst",  fetch_inst,  16'h0000);
        fetch_req = 1'b0;
        step();

        // Three-word download terminated by load_last.
        ld[0] = 16'h1C0A; ld[1] = 16'h1E0B; ld[2] = 16'hFC00;
        start_load("ld3");
        load_words("ld3", 3, 1'b1);
        fetch_list("ld3_fetch", '{0, 1, 2, 3});

        // Full-depth download without load_last ends at the top word.
        ld[0] = 16'h1C0A;
        for (int k = 1; k < DEPTH; k++) ld[k] = 16'($urandom);
        start_load("ld16");
        load_words("ld16", DEPTH, 1'b0);
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = 16'hDEAD;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("run_valid_ignored_busy", busy, 0);
        step();
        check("run_valid_ignored_done", load_done, 0);
        fetch_list("ld16_fetch", '{15, 0, 14});

        // Fetch accepted together with load_start sees pre-load contents.
        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 4'd0;
        step();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        check("overlap_valid", fetch_valid, 1);
        check("overlap_inst",  fetch_inst,  16'h1C0A);
        check("overlap_busy",  busy,        1);
        ld[0] = 16'hAAAA;
        load_words("overlap_ld", 1, 1'b1);
        fetch_list("overlap_fetch", '{0});

        // Randomized downloads followed by randomized fetch streams.
        for (int r = 0; r < 6; r++) begin
            int  n  = $urandom_range(1, DEPTH);
            bit  ul = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int k = 0; k < DEPTH; k++) ld[k] = 16'($urandom);
            start_load("rnd");
            load_words("rnd_ld", n, ul);
            for (int k = 0; k < 12; k++) begin
                logic       req = ($urandom_range(0, 3) != 0);
                logic [3:0] a   = 4'($urandom);
                fetch_req  = req;
                fetch_addr = a;
                step();
                check("rnd_valid", fetch_valid, req);
                if (req) exp_hold = model_mem[a];
                check("rnd_inst", fetch_inst, exp_hold);
            end
            fetch_req = 1'b0;
            step();
        end

        // DEPTH=12 instance: range boundary and out-of-range handling.
        begin
            int         b_addrs[4] = '{11, 12, 13, 5};
            logic [0:0] b_err[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
            foreach (b_addrs[i]) begin
                b_fetch_req  = 1'b1;
                b_fetch_addr = b_addrs[i][ADDR_W-1:0];
                step();
                check("d12_valid", b_fetch_valid, 1);
                check("d12_inst",  b_fetch_inst,  NOP12);
                check("d12_err",   b_fetch_err,   b_err[i]);
            end
            b_fetch_req  = 1'b1;
            b_fetch_addr = 4'd13;
            step();
            b_fetch_req  = 1'b0;
            check("d12_oor_err", b_fetch_err, 1);
            step();
            check("d12_err_pulse_end", b_fetch_err,   0);
            check("d12_valid_end",     b_fetch_valid, 0);
            check("d12_inst_hold",     b_fetch_inst,  NOP12);
        end

        // Reset in the middle of a five-word download.
        start_load("abort");
        for (int k = 0; k < 2; k++) begin
            load_valid = 1'b1;
            load_data  = 16'h5A00 + 16'(k);
            load_last  = 1'b0;
            step();
        end
        load_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("abort_rst");
        step();
        rst_n = 1'b1;
        for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
        measure_clear("abort");
        step();
        fetch_list("abort_fetch", '{0, 1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
